// File: rtl/gate3_pattern_checker_pkg.sv
// Shared definitions for the 3-input gate pattern checker: FSM state
// encodings, gate function codes and sweep constants.
package gate3_pattern_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FUNC_AND  = 2'd0,
        FUNC_OR   = 2'd1,
        FUNC_NAND = 2'd2,
        FUNC_NOR  = 2'd3
    } func_t;

    localparam logic [2:0] LAST_PATTERN = 3'd7;
    localparam int         SETTLE_W     = 4;

endpackage

// File: rtl/gate3_pattern_checker_model.sv
// Combinational reference for the expected output of an ideal 3-input gate
// for a given input pattern and function code.
module gate3_model
    import gate3_pattern_checker_pkg::*;
(
    input  logic [2:0] pattern,
    input  logic [1:0] func,
    output logic       expected
);

    logic and3;
    logic or3;

    assign and3 = &pattern;
    assign or3  = |pattern;

    always_comb begin
        case (func_t'(func))
            FUNC_AND:  expected = and3;
            FUNC_OR:   expected = or3;
            FUNC_NAND: expected = ~and3;
            default:   expected = ~or3;
        endcase
    end

endmodule

// File: rtl/gate3_pattern_checker.sv
// Sweeps all eight input patterns into a 3-input gate under test, holding
// each for SETTLE_CYCLES before sampling, and reports mismatch statistics.
module gate3_pattern_checker
    import gate3_pattern_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       in_CLK,
    input  logic       in_RST,
    input  logic       in_START,
    input  logic [1:0] in_FUNC,
    input  logic       in_Y,
    output logic       out_A,
    output logic       out_B,
    output logic       out_C,
    output logic       out_BUSY,
    output logic       out_DONE,
    output logic       out_PASS,
    output logic [3:0] out_ERR_CNT,
    output logic [2:0] out_FIRST_FAIL,
    output logic       out_FAIL_VALID
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [2:0]          pattern_q, pattern_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [1:0]          func_q, func_d;
    logic [3:0]          err_q, err_d;
    logic [2:0]          first_q, first_d;
    logic                fv_q, fv_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                expected;

    gate3_model u_model (
        .pattern  (pattern_q),
        .func     (func_q),
        .expected (expected)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
        state_d   = state_q;
        pattern_d = pattern_q;
        settle_d  = settle_q;
        func_d    = func_q;
        err_d     = err_q;
        first_d   = first_q;
        fv_d      = fv_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (in_START) begin
                    state_d   = ST_DRIVE;
                    pattern_d = 3'd0;
                    settle_d  = '0;
                    func_d    = in_FUNC;
                    err_d     = 4'd0;
                    first_d   = 3'd0;
                    fv_d      = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            default: begin
                // Eight samples at most, so err_q cannot pass 8.
                if (in_Y != expected) begin
                    err_d = err_q + 4'd1;
                    if (!fv_q) begin
                        first_d = pattern_q;
                        fv_d    = 1'b1;
                    end
                end
                if (pattern_q == LAST_PATTERN) begin
                    state_d = ST_DONE;
                end else begin
                    pattern_d = pattern_q + 3'd1;
                    state_d   = ST_DRIVE;
                end
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == 4'd0);
    end

    always_ff @(posedge in_CLK) begin
        // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
        if (in_RST) begin
            state_q   <= ST_IDLE;
            pattern_q <= 3'd0;
            settle_q  <= '0;
            func_q    <= 2'd0;
            err_q     <= 4'd0;
            first_q   <= 3'd0;
            fv_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            settle_q  <= settle_d;
            func_q    <= func_d;
            err_q     <= err_d;
            first_q   <= first_d;
            fv_q      <= fv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign out_A          = pattern_q[2];
    assign out_B          = pattern_q[1];
    assign out_C          = pattern_q[0];
    assign out_BUSY       = busy_q;
    assign out_DONE       = done_q;
    assign out_PASS       = pass_q;
    assign out_ERR_CNT    = err_q;
    assign out_FIRST_FAIL = first_q;
    assign out_FAIL_VALID = fv_q;

endmodule

// File: tb/tb_gate3_pattern_checker.sv
// Self-checking bench: three checkers (SETTLE 2, 1, 15) compared every cycle
// against a sweep-timeline model, plus directed literal expectations.
module tb_gate3_pattern_checker;

    typedef enum int {Y_IDEAL_AND, Y_STUCK1, Y_STUCK0, Y_RANDOM} y_mode_t;

    function automatic int settle_of(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic int done_lit(int i);
        case (i)
            0:       return 24;
            1:       return 16;
            default: return 128;
        endcase
    endfunction

    function automatic logic spec_expect(logic [1:0] f, int p);
        case (f)
            2'd0:    return p == 7;
            2'd1:    return p != 0;
            2'd2:    return p != 7;
            default: return p == 0;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] func;
    logic [2:0] y;
    logic [2:0] a, b, c, busy, done, pass_o, fv;
    logic [3:0] err   [3];
    logic [2:0] first [3];

    y_mode_t mode      = Y_IDEAL_AND;
    bit      check_en  = 1'b0;
    int      pass_cnt  = 0;
    int      total_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gate3_pattern_checker #(.SETTLE_CYCLES(settle_of(g))) u_dut (
            .in_CLK         (clk),
            .in_RST         (rst),
            .in_START       (start),
            .in_FUNC        (func),
            .in_Y           (y[g]),
            .out_A          (a[g]),
            .out_B          (b[g]),
            .out_C          (c[g]),
            .out_BUSY       (busy[g]),
            .out_DONE       (done[g]),
            .out_PASS       (pass_o[g]),
            .out_ERR_CNT    (err[g]),
            .out_FIRST_FAIL (first[g]),
            .out_FAIL_VALID (fv[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Gate under test, driven away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            case (mode)
                Y_IDEAL_AND: y[i] = a[i] & b[i] & c[i];
                Y_STUCK1:    y[i] = 1'b1;
                Y_STUCK0:    y[i] = 1'b0;
                default:     y[i] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Model: time since the accepted start decides pattern and sample points.
    bit         m_run   [3];
    int         m_t     [3];
    logic [2:0] m_pat   [3];
    logic [3:0] m_err   [3];
    logic [2:0] m_first [3];
    bit         m_fv    [3];
    bit         m_done  [3];
    logic [1:0] m_func  [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int per;
            per = settle_of(i) + 1;
            if (rst) begin
                m_run[i] = 0; m_done[i] = 0; m_pat[i] = 0; m_t[i] = 0;
                m_err[i] = 0; m_first[i] = 0; m_fv[i] = 0; m_func[i] = 0;
            end else if (!m_run[i] && start) begin
                m_run[i] = 1; m_done[i] = 0; m_pat[i] = 0; m_t[i] = 0;
                m_err[i] = 0; m_first[i] = 0; m_fv[i] = 0; m_func[i] = func;
            end else if (m_run[i]) begin
                m_t[i]++;
                if (m_t[i] % per == 0) begin
                    int p;
                    p = m_t[i] / per - 1;
                    if (y[i] != spec_expect(m_func[i], p)) begin
                        m_err[i]++;
                        if (!m_fv[i]) begin
                            m_fv[i] = 1;
                            m_first[i] = 3'(p);
                        end
                    end
                    if (p == 7) begin
                        m_run[i]  = 0;
                        m_done[i] = 1;
                    end else begin
                        m_pat[i] = 3'(p + 1);
                    end
                end
            end
        end
    end

    // Per-cycle compare plus stimulus hold/step monitor.
    logic [2:0] prev_abc  [3];
    bit         prev_busy [3];
    int         run_len   [3];

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [13:0] act, exp;
                logic [2:0]  cur;
                act = {a[i], b[i], c[i], busy[i], done[i], pass_o[i], err[i], first[i], fv[i]};
                exp = {m_pat[i], m_run[i], m_done[i], m_done[i] && (m_err[i] == 0),
                       m_err[i], m_first[i], m_fv[i]};
                check($sformatf("model_dut%0d", i), 32'(act), 32'(exp));

                cur = {a[i], b[i], c[i]};
                if (busy[i] && !prev_busy[i]) begin
                    check($sformatf("first_pattern_dut%0d", i), 32'(cur), 32'd0);
                    run_len[i] = 1;
                end else if (busy[i] && cur != prev_abc[i]) begin
                    check($sformatf("hold_len_dut%0d", i), run_len[i], settle_of(i) + 1);
                    check($sformatf("step_dut%0d", i), 32'(cur), 32'(3'(prev_abc[i] + 3'd1)));
                    run_len[i] = 1;
                end else if (done[i] && prev_busy[i]) begin
                    check($sformatf("last_hold_dut%0d", i), run_len[i], settle_of(i) + 1);
                end else begin
                    run_len[i]++;
                end
                prev_abc[i]  = cur;
                prev_busy[i] = busy[i];
            end
        end
    end

    task automatic run_sweep(input logic [1:0] f, input y_mode_t m, input bit repulse,
                             input int e_err, input int e_first, input bit e_fv, input bit e_pass);
        int cyc;
        int done_at [3];
        mode  = m;
        func  = f;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cyc     = 0;
        done_at = '{0, 0, 0};
        while (cyc < 300 && (done_at[0] == 0 || done_at[1] == 0 || done_at[2] == 0)) begin
            @(negedge clk);
            cyc++;
            if (repulse && cyc == 9) begin
                start = 1'b1;
                func  = ~f;
            end
            if (cyc == 10) begin
                start = 1'b0;
                func  = f;
            end
            for (int i = 0; i < 3; i++)
                if (done[i] && done_at[i] == 0) done_at[i] = cyc;
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("done_time_dut%0d", i), done_at[i], done_lit(i));
        check("err_cnt",    32'(err[0]),   e_err);
        check("first_fail", 32'(first[0]), e_first);
        check("fail_valid", 32'(fv[0]),    32'(e_fv));
        check("pass",       32'(pass_o[0]), 32'(e_pass));
    endtask

    task automatic reset_mid_sweep();
        bit saw_done;
        mode  = Y_STUCK1;
        func  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 11; cyc++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs",
              32'({a[0], b[0], c[0], busy[0], done[0], pass_o[0], err[0], first[0], fv[0]}), 32'd0);
        saw_done = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done[0] || busy[0]) saw_done = 1;
        end
        check("no_done_after_rst", 32'(saw_done), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        func  = 2'd0;
        y     = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_state",
              32'({a[0], b[0], c[0], busy[0], done[0], pass_o[0], err[0], first[0], fv[0]}), 32'd0);
        check_en = 1'b1;
        rst      = 1'b0;
        @(negedge clk);

        run_sweep(2'd0, Y_IDEAL_AND, 1'b0, 0, 0, 1'b0, 1'b1);
        run_sweep(2'd0, Y_STUCK1,    1'b0, 7, 0, 1'b1, 1'b0);
        run_sweep(2'd0, Y_STUCK0,    1'b0, 1, 7, 1'b1, 1'b0);
        run_sweep(2'd1, Y_IDEAL_AND, 1'b0, 6, 1, 1'b1, 1'b0);
        run_sweep(2'd2, Y_IDEAL_AND, 1'b1, 8, 0, 1'b1, 1'b0);
        run_sweep(2'd3, Y_IDEAL_AND, 1'b0, 2, 0, 1'b1, 1'b0);
        reset_mid_sweep();

        mode = Y_RANDOM;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 19) == 0);
            func  = 2'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 199) == 0);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
